// File: rtl/sema_wr_arbiter.sv
// Round-robin write arbiter in front of the sema bit-semaphore pair: one write per grant,
// then a COOLDOWN hold so is_empty settles. Optional grant counters under SEMA_WR_ARB_STATS_EN.
module sema_wr_arbiter #(
  parameter int unsigned COOLDOWN = 2
) (
  input  logic        clk_s,
  input  logic        rst_s,
  input  logic        req_A_s,
  input  logic        data_A_s,
  output logic        gnt_A_s,
  input  logic        req_B_s,
  input  logic        data_B_s,
  output logic        gnt_B_s,
  input  logic        is_empty_A_s,
  input  logic        is_empty_B_s,
  output logic        sema_write_o_s_A,
  output logic        sema_data_o_s_A,
  output logic        sema_write_o_s_B,
  output logic        sema_data_o_s_B,
`ifdef SEMA_WR_ARB_STATS_EN
  output logic [15:0] gnt_cnt_A_s,
  output logic [15:0] gnt_cnt_B_s,
`endif
  output logic        busy_s
);

  localparam logic [3:0] CoolInit = 4'(COOLDOWN);

  typedef enum logic [1:0] {StIdle, StGrant, StCool} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;    // 0 = A, 1 = B
  logic       sel_q, sel_d;
  logic       wdata_q, wdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic       elig_a, elig_b, pick;
  logic       gnt_a_d, gnt_b_d, dat_a_d, dat_b_d, busy_d;

  assign elig_a = req_A_s & is_empty_A_s;
  assign elig_b = req_B_s & is_empty_B_s;
  // On a tie the requester that did not win last time goes first.
  assign pick   = (elig_a && elig_b) ? ~last_q : elig_b;

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      wdata_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (elig_a || elig_b) begin
          sel_d   = pick;
          wdata_d = pick ? data_B_s : data_A_s;
          state_d = StGrant;
        end
      end
      StGrant: begin
        last_d  = sel_q;
        cnt_d   = CoolInit;
        state_d = StCool;
      end
      StCool: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they are registered yet aligned with GRANT.
  always_comb begin
    gnt_a_d = (state_d == StGrant) && !sel_d;
    gnt_b_d = (state_d == StGrant) && sel_d;
    dat_a_d = gnt_a_d & wdata_d;
    dat_b_d = gnt_b_d & wdata_d;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      gnt_A_s          <= 1'b0;
      gnt_B_s          <= 1'b0;
      sema_write_o_s_A <= 1'b0;
      sema_write_o_s_B <= 1'b0;
      sema_data_o_s_A  <= 1'b0;
      sema_data_o_s_B  <= 1'b0;
      busy_s           <= 1'b0;
    end else begin
      gnt_A_s          <= gnt_a_d;
      gnt_B_s          <= gnt_b_d;
      sema_write_o_s_A <= gnt_a_d;
      sema_write_o_s_B <= gnt_b_d;
      sema_data_o_s_A  <= dat_a_d;
      sema_data_o_s_B  <= dat_b_d;
      busy_s           <= busy_d;
    end
  end

`ifdef SEMA_WR_ARB_STATS_EN
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      gnt_cnt_A_s <= 16'd0;
      gnt_cnt_B_s <= 16'd0;
    end else if (state_q == StGrant) begin
      if (!sel_q && gnt_cnt_A_s != 16'hffff) gnt_cnt_A_s <= gnt_cnt_A_s + 16'd1;
      if (sel_q && gnt_cnt_B_s != 16'hffff) gnt_cnt_B_s <= gnt_cnt_B_s + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sema_wr_arbiter.sv
// Randomized bench for sema_wr_arbiter: COOLDOWN=2 and COOLDOWN=1 instances share stimulus
// and are compared against a schedule model (next-free cycle + round-robin pointer).
module tb_sema_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req_a, data_a, req_b, data_b, emp_a, emp_b;
  logic [1:0] gnt_a, gnt_b, wr_a, wr_b, dat_a, dat_b, busy;
`ifdef SEMA_WR_ARB_STATS_EN
  logic [15:0] cnt_a [2];
  logic [15:0] cnt_b [2];
`endif

  always #5 clk = ~clk;

  sema_wr_arbiter #(.COOLDOWN(2)) dut (
    .clk_s(clk), .rst_s(rst),
    .req_A_s(req_a), .data_A_s(data_a), .gnt_A_s(gnt_a[0]),
    .req_B_s(req_b), .data_B_s(data_b), .gnt_B_s(gnt_b[0]),
    .is_empty_A_s(emp_a), .is_empty_B_s(emp_b),
    .sema_write_o_s_A(wr_a[0]), .sema_data_o_s_A(dat_a[0]),
    .sema_write_o_s_B(wr_b[0]), .sema_data_o_s_B(dat_b[0]),
`ifdef SEMA_WR_ARB_STATS_EN
    .gnt_cnt_A_s(cnt_a[0]), .gnt_cnt_B_s(cnt_b[0]),
`endif
    .busy_s(busy[0])
  );

  sema_wr_arbiter #(.COOLDOWN(1)) dut1 (
    .clk_s(clk), .rst_s(rst),
    .req_A_s(req_a), .data_A_s(data_a), .gnt_A_s(gnt_a[1]),
    .req_B_s(req_b), .data_B_s(data_b), .gnt_B_s(gnt_b[1]),
    .is_empty_A_s(emp_a), .is_empty_B_s(emp_b),
    .sema_write_o_s_A(wr_a[1]), .sema_data_o_s_A(dat_a[1]),
    .sema_write_o_s_B(wr_b[1]), .sema_data_o_s_B(dat_b[1]),
`ifdef SEMA_WR_ARB_STATS_EN
    .gnt_cnt_A_s(cnt_a[1]), .gnt_cnt_B_s(cnt_b[1]),
`endif
    .busy_s(busy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: a grant decided at edge g is visible after g, the next decision is
  // possible at edge g+COOLDOWN+2, and busy covers edges g..g+COOLDOWN.
  int          edge_n;
  int          cool [2] = '{2, 1};
  int          free_at [2];
  int          gedge [2];
  logic        last [2];
  logic        msel [2];
  logic        exp_ga [2];
  logic        exp_gb [2];
  logic        exp_d [2];
  logic [15:0] mcnt_a [2];
  logic [15:0] mcnt_b [2];

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0;
      gedge[i]   = -100;
      last[i]    = 1'b1;
      msel[i]    = 1'b0;
      exp_ga[i]  = 1'b0;
      exp_gb[i]  = 1'b0;
      exp_d[i]   = 1'b0;
      mcnt_a[i]  = 16'd0;
      mcnt_b[i]  = 16'd0;
    end
  endtask

  task automatic step();
    int  e;
    logic ea, eb, pk, bz;
    @(posedge clk);
    e = edge_n;
    for (int i = 0; i < 2; i++) begin
      if (gedge[i] + 1 == e) begin
        if (!msel[i] && mcnt_a[i] != 16'hffff) mcnt_a[i] = mcnt_a[i] + 16'd1;
        if (msel[i] && mcnt_b[i] != 16'hffff) mcnt_b[i] = mcnt_b[i] + 16'd1;
      end
      exp_ga[i] = 1'b0;
      exp_gb[i] = 1'b0;
      exp_d[i]  = 1'b0;
      if (e >= free_at[i]) begin
        ea = req_a & emp_a;
        eb = req_b & emp_b;
        if (ea || eb) begin
          pk         = (ea && eb) ? !last[i] : eb;
          last[i]    = pk;
          msel[i]    = pk;
          gedge[i]   = e;
          free_at[i] = e + cool[i] + 2;
          exp_ga[i]  = !pk;
          exp_gb[i]  = pk;
          exp_d[i]   = pk ? data_b : data_a;
        end
      end
    end
    edge_n++;
    #1;
    for (int i = 0; i < 2; i++) begin
      bz = (e >= gedge[i]) && (e <= gedge[i] + cool[i]);
      check($sformatf("gnt_a[%0d]@%0d", i, e), 16'(gnt_a[i]), 16'(exp_ga[i]));
      check($sformatf("gnt_b[%0d]@%0d", i, e), 16'(gnt_b[i]), 16'(exp_gb[i]));
      check($sformatf("wr_a[%0d]@%0d", i, e), 16'(wr_a[i]), 16'(exp_ga[i]));
      check($sformatf("wr_b[%0d]@%0d", i, e), 16'(wr_b[i]), 16'(exp_gb[i]));
      check($sformatf("dat_a[%0d]@%0d", i, e), 16'(dat_a[i]), 16'(exp_ga[i] & exp_d[i]));
      check($sformatf("dat_b[%0d]@%0d", i, e), 16'(dat_b[i]), 16'(exp_gb[i] & exp_d[i]));
      check($sformatf("busy[%0d]@%0d", i, e), 16'(busy[i]), 16'(bz));
`ifdef SEMA_WR_ARB_STATS_EN
      check($sformatf("cnt_a[%0d]@%0d", i, e), cnt_a[i], mcnt_a[i]);
      check($sformatf("cnt_b[%0d]@%0d", i, e), cnt_b[i], mcnt_b[i]);
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_outs[%0d]", tag, i),
            16'({gnt_a[i], gnt_b[i], wr_a[i], wr_b[i], dat_a[i], dat_b[i], busy[i]}), 16'd0);
`ifdef SEMA_WR_ARB_STATS_EN
      check($sformatf("%s_cnt[%0d]", tag, i), cnt_a[i] | cnt_b[i], 16'd0);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    {req_a, data_a, req_b, data_b, emp_a, emp_b} = '0;
    model_reset();
    do_reset();

    // A only
    req_a = 1'b1; data_a = 1'b1; emp_a = 1'b1;
    repeat (12) step();

    // Both requesting, both empty: alternation
    req_b = 1'b1; emp_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_a = 1'($urandom);
      data_b = 1'($urandom);
      step();
    end

    // A's target full, then freed
    emp_a = 1'b0;
    repeat (8) step();
    emp_a = 1'b1;
    repeat (8) step();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      emp_a  = ($urandom_range(0, 4) != 0);
      emp_b  = ($urandom_range(0, 4) != 0);
      data_a = 1'($urandom);
      data_b = 1'($urandom);
      step();
    end

    // Reset in the middle of a GRANT cycle
    req_a = 1'b1; req_b = 1'b1; emp_a = 1'b1; emp_b = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!exp_ga[0] && !exp_gb[0] && n < 10);
    check("grant_before_reset", 16'(gnt_a[0] | gnt_b[0]), 16'd1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    check("first_after_reset", 16'(gnt_a[0]), 16'd1);
    repeat (10) step();

`ifdef SEMA_WR_ARB_STATS_EN
    // Saturation: preload near the top and issue three more A grants
    do_reset();
    req_b = 1'b0;
    @(negedge clk);
    dut.gnt_cnt_A_s  = 16'hfffd;
    dut1.gnt_cnt_A_s = 16'hfffd;
    mcnt_a[0] = 16'hfffd;
    mcnt_a[1] = 16'hfffd;
    repeat (14) step();
    check("cnt_a_saturated", cnt_a[0], 16'hffff);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
